// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator with run-time rate updates.
// Optional CLK_ENABLE_GEN_PHASE_ALIGN_EN adds sync_in for phase alignment.
module clk_enable_gen #(
  parameter int          NUM_CH      = 2,
  parameter int          ACC_W       = 32,
  parameter int          LOCK_CYCLES = 16,
  parameter logic [31:0] DEFAULT_INC = 32'h3EEA209A
) (
  input  logic              refclk,
  input  logic              rst_n,
`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int CNT_W =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(LOCK_CYCLES - 1);
  localparam logic [3:0] CH_LIM = 4'(NUM_CH);
  localparam logic [ACC_W-1:0] INC_RST =
    DEFAULT_INC[ACC_W-1:0];

  typedef enum logic [1:0] {
    SETTLE,
    IDLE,
    PENDING
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [2:0]        pend_ch;
  logic [ACC_W-1:0]  pend_inc;
  logic              pend_ld;
  logic              ch_ok;
  logic              sync;
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] inc_zero;
  logic [NUM_CH-1:0] commit;

`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  assign ch_ok = ({1'b0, cfg_ch} < CH_LIM);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic             ce_q;
    logic             oc_q;

    assign sum         = {1'b0, acc} + {1'b0, inc};
    assign carry[i]    = sum[ACC_W];
    assign inc_zero[i] = (inc == '0);
    // Swap only at the period boundary; a frozen channel swaps at once.
    assign commit[i]   = (state == PENDING)
                       && (pend_ch == 3'(i))
                       && (sync || carry[i] || inc_zero[i]);

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        acc  <= '0;
        ce_q <= 1'b0;
        oc_q <= 1'b0;
      end else if (sync) begin
        acc  <= '0;
        ce_q <= 1'b0;
        oc_q <= 1'b0;
      end else begin
        acc  <= sum[ACC_W-1:0];
        ce_q <= sum[ACC_W];
        oc_q <= sum[ACC_W-1];
      end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        inc <= INC_RST;
      end else if (commit[i]) begin
        inc <= pend_inc;
      end
    end

    assign ce[i]     = ce_q;
    assign outclk[i] = oc_q;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ch  <= '0;
      pend_inc <= '0;
    end else if (pend_ld) begin
      pend_ch  <= cfg_ch;
      pend_inc <= cfg_inc;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pend_ld = 1'b0;
    unique case (state)
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        // Out-of-range channels are consumed and dropped.
        if (cfg_valid && ch_ok) begin
          state_d = PENDING;
          pend_ld = 1'b1;
        end
      end
      PENDING: begin
        if (|commit) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cfg_ready = (state == IDLE);
  assign locked    = (state == IDLE);

endmodule
